// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: FSM state encoding and record layout shared by the register dump reader.
package reg_dump_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  localparam int BYTES_PER_REG = 5;
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REG - 1);
endpackage

// File: rtl/reg_dump_ser.sv
// reg_dump_ser: snapshots one 32-bit register and streams {index, word MSB..LSB} over valid/ready.
module reg_dump_ser
  import reg_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        send,
  input  logic        clr,
  input  logic [31:0] word_in,
  input  logic [4:0]  index,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        last
);
  logic [31:0] word_q;
  logic [2:0]  cnt_q;
  logic        acc;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      cnt_q  <= '0;
    end else if (acc) cnt_q <= cnt_q + 3'd1;
  // Byte selection depends only on registered state, so data holds steady under backpressure.
  always_comb begin
    acc     = send && tx_ready;
    last    = acc && cnt_q == LAST_BYTE;
    tx_data = !send       ? 8'h00 :
              cnt_q == 3'd0 ? {3'b000, index} :
              cnt_q == 3'd1 ? word_q[31:24] :
              cnt_q == 3'd2 ? word_q[23:16] :
              cnt_q == 3'd3 ? word_q[15:8]  : word_q[7:0];
  end
endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices FIRST_REG..LAST_REG through the debug read port
// and emits a 5-byte record per register on a valid/ready byte stream.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  req_dbg,
  input  logic [31:0] data_dbg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);
  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       last;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  // Increment is only taken below LAST, so the index never wraps past 31.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        idx_d   = FIRST;
      end
      LOAD: state_d = SEND;
      SEND: if (last) begin
        state_d = idx_q == LAST ? DONE : LOAD;
        idx_d   = idx_q == LAST ? idx_q : idx_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end
  always_comb begin
    busy     = state_q != IDLE;
    done     = state_q == DONE;
    tx_valid = state_q == SEND;
    req_dbg  = (state_q == LOAD || state_q == SEND) ? idx_q : 5'd0;
  end
  reg_dump_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == LOAD),
    .send     (state_q == SEND),
    .clr      (abort),
    .word_in  (data_dbg),
    .index    (idx_q),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .last     (last)
  );
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed checks of a full-range reader and a single-register reader.
module tb_reg_dump_reader;
  logic        clk, rst_n;
  logic        start_a, abort_a, ready_a, valid_a, busy_a, done_a;
  logic [4:0]  req_a;
  logic [31:0] data_a;
  logic [7:0]  tx_a;
  logic        start_b, abort_b, ready_b, valid_b, busy_b, done_b;
  logic [4:0]  req_b;
  logic [31:0] data_b;
  logic [7:0]  tx_b;
  logic [31:0] rf [32];
  int          errors = 0, checks = 0;

  assign data_a = rf[req_a];
  assign data_b = rf[req_b];

  reg_dump_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .req_dbg(req_a),
    .data_dbg(data_a), .tx_data(tx_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .busy(busy_a), .done(done_a)
  );
  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .req_dbg(req_b),
    .data_dbg(data_b), .tx_data(tx_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start, ready, abort;
    logic       valid;
    logic [7:0] data;
    logic       done, busy;
    logic [4:0] req;
  } vec_t;
  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int p);
    int          rec = p / 5;
    int          pos = p % 5;
    logic [31:0] w;
    if (rec > 31) return 8'hxx;
    w = rf[rec];
    return pos == 0 ? 8'(rec) : w[8*(4-pos) +: 8];
  endfunction

  task automatic seek(input int target, inout int acc);
    int c;
    for (c = 0; c < 400; c++) begin
      if (valid_a && acc == target) break;
      if (valid_a && ready_a) acc++;
      step();
    end
    chk("seek_reached", 32'(c < 400), 32'd1);
  endtask

  task automatic run_pass();
    int cyc = 0, n = 0, d = 0;
    ready_a = 1;
    start_a = 1;
    step();
    start_a = 0;
    for (int c = 0; c < 1000 && busy_a; c++) begin
      cyc++;
      if (done_a) d++;
      if (valid_a) begin
        chk($sformatf("pass_byte%0d", n), tx_a, exp_byte(n));
        n++;
      end
      step();
    end
    chk("pass_cycles", cyc, 193);
    chk("pass_bytes", n, 160);
    chk("pass_dones", d, 1);
    chk("pass_idle", busy_a, 0);
  endtask

  initial begin
    int acc, d;
    rst_n = 0;
    {start_a, abort_a, start_b, abort_b} = '0;
    ready_a = 1;
    ready_b = 1;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    rf[5] = 32'hDEADBEEF;
    step();
    step();
    chk("rst_busy_a", busy_a, 0);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_data_a", tx_a, 0);
    chk("rst_req_a", req_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1;
    step();

    //            st   rdy  ab   vld  data   dn   bsy  req
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,5'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,5'd5};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,8'h05,1'b0,1'b1,5'd5};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,8'hDE,1'b0,1'b1,5'd5};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,8'hAD,1'b0,1'b1,5'd5};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,8'hBE,1'b0,1'b1,5'd5};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,8'hEF,1'b0,1'b1,5'd5};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b1,5'd0};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,5'd0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,5'd5};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,8'h05,1'b0,1'b1,5'd5};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b1,8'h05,1'b0,1'b1,5'd5};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1,8'hDE,1'b0,1'b1,5'd5};
    tbl[13] = '{1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,5'd0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,5'd0};
    for (int i = 0; i < 15; i++) begin
      start_b = tbl[i].start;
      ready_b = tbl[i].ready;
      abort_b = tbl[i].abort;
      chk($sformatf("v%0d_valid", i), valid_b, tbl[i].valid);
      chk($sformatf("v%0d_data", i), tx_b, tbl[i].data);
      chk($sformatf("v%0d_done", i), done_b, tbl[i].done);
      chk($sformatf("v%0d_busy", i), busy_b, tbl[i].busy);
      chk($sformatf("v%0d_req", i), req_b, tbl[i].req);
      step();
    end
    {start_b, abort_b} = '0;

    rf[5] = 32'h05050505;
    run_pass();

    rf[7] = 32'h12345678;
    start_a = 1;
    step();
    start_a = 0;
    acc = 0;
    seek(37, acc);
    chk("bp_first", tx_a, 8'h34);
    ready_a = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", tx_a, 8'h34);
      chk("bp_valid", valid_a, 1);
      step();
    end
    chk("bp_still", tx_a, 8'h34);
    ready_a = 1;
    step();
    chk("bp_next", tx_a, 8'h56);
    acc = 38;
    seek(53, acc);
    chk("ab_byte", tx_a, 8'h0A);
    chk("ab_req", req_a, 5'd10);
    abort_a = 1;
    step();
    abort_a = 0;
    chk("ab_valid", valid_a, 0);
    chk("ab_busy", busy_a, 0);
    chk("ab_data", tx_a, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ab_no_done", done_a, 0);
      step();
    end

    start_a = 1;
    step();
    start_a = 0;
    chk("rs_req", req_a, 5'd0);
    chk("rs_busy", busy_a, 1);
    step();
    chk("rs_byte0", tx_a, 8'h00);
    acc = 0;
    seek(15, acc);
    chk("snap_idx", tx_a, 8'h03);
    rf[3] = 32'hCAFEF00D;
    start_a = 1;
    step();
    start_a = 0;
    for (int i = 0; i < 4; i++) begin
      chk("snap_old", tx_a, 8'h03);
      step();
    end
    d = 0;
    for (int c = 0; c < 400 && busy_a; c++) begin
      if (done_a) d++;
      step();
    end
    chk("snap_dones", d, 1);
    step();
    step();
    chk("snap_no_restart", busy_a, 0);

    start_a = 1;
    step();
    start_a = 0;
    repeat (20) step();
    chk("mid_busy", busy_a, 1);
    rst_n = 0;
    abort_a = 1;
    start_a = 1;
    step();
    chk("mr_busy", busy_a, 0);
    chk("mr_valid", valid_a, 0);
    chk("mr_data", tx_a, 0);
    chk("mr_req", req_a, 0);
    chk("mr_done", done_a, 0);
    rst_n = 1;
    abort_a = 0;
    start_a = 0;
    step();
    chk("mr_idle_done", done_a, 0);
    chk("mr_idle_busy", busy_a, 0);
    run_pass();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter FIRST_REG, default 0, first register index dumped (0..31).
REQ-002 Parameter LAST_REG, default 31, last register index dumped (FIRST_REG..31).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request one dump pass; sampled only in IDLE.
REQ-006 abort  input  1  terminate pass; returns to IDLE next edge, no done pulse.
REQ-007 req_dbg  output  5  register index driven to register-file debug read port.
REQ-008 data_dbg  input  32  combinational read data for req_dbg.
REQ-009 tx_data  output  8  byte stream data.
REQ-010 tx_valid  output  1  tx_data valid.
REQ-011 tx_ready  input  1  downstream accepts byte when tx_valid && tx_ready at rising edge.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 done  output  1  one-cycle pulse after last byte of pass accepted.

Function
REQ-014 FSM SHALL have states IDLE, LOAD, SEND, DONE.
REQ-015 IDLE: start=1 && abort=0 -> LOAD, index <= FIRST_REG; start otherwise ignored.
REQ-016 LOAD: req_dbg = index; data_dbg latched into 32-bit word register; byte count <= 0; -> SEND (exactly one cycle).
REQ-017 req_dbg SHALL hold the current index in LOAD and SEND; 0 in IDLE and DONE.
REQ-018 Per register SHALL emit 5 bytes in order: {3'b000,index}, word[31:24], word[23:16], word[15:8], word[7:0].
REQ-019 SEND: tx_valid=1; tx_data = byte selected by byte count; byte count advances only on tx_valid && tx_ready.
REQ-020 While tx_valid=1 && tx_ready=0, tx_data SHALL be stable (abort and reset excepted).
REQ-021 Acceptance of byte 4: index == LAST_REG -> DONE; else index <= index+1 -> LOAD.
REQ-022 Index increment SHALL NOT wrap; LAST_REG=31 terminates without computing 32.
REQ-023 DONE: done=1 for exactly one cycle, tx_valid=0 -> IDLE.
REQ-024 Latency: start accepted at edge N -> tx_valid first high in cycle after edge N+1.
REQ-025 With tx_ready held 1, a pass SHALL take 6*(LAST_REG-FIRST_REG+1)+1 cycles from leaving IDLE to returning to IDLE.
REQ-026 Each word SHALL be a snapshot taken in its LOAD cycle; writes to that register after LOAD are not reflected until the next pass.
REQ-027 abort in LOAD, SEND or DONE: next edge -> IDLE, tx_valid=0, done=0, word discarded; abort beats tx_ready and start in the same cycle.
REQ-028 FIRST_REG == LAST_REG SHALL produce exactly one 5-byte record.
REQ-029 Register 0 SHALL be dumped as read (register file returns zero); no special casing.

Reset
REQ-030 rst_n=0 at rising edge: state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, req_dbg=0; index and byte count 0.
REQ-031 Reset mid-pass SHALL discard the pass without a done pulse; reset dominates abort and start.

Structure
REQ-032 Shared package SHALL hold the FSM state enumeration and constant BYTES_PER_REG = 5.
REQ-033 One sub-module reg_dump_ser: 32-bit word + index -> 5-byte valid/ready serializer; FSM and index counter stay in top.

Verification
REQ-034 Regfile preset r5=32'hDEADBEEF, FIRST=LAST=5, tx_ready=1, pulse start -> bytes 05 DE AD BE EF on consecutive cycles, done 1 cycle later, busy low after.
REQ-035 Default params, tx_ready=1, r[i]=i*32'h01010101 -> 160 bytes, record i = {i, i, i, i, i}, 193 cycles, one done pulse.
REQ-036 Backpressure: tx_ready low 3 cycles while presenting byte 2 of r7=32'h12345678 -> tx_data holds 34 throughout, next byte 56 only after ready.
REQ-037 abort asserted during byte 3 of record 10 -> next cycle IDLE, tx_valid=0, no done; later start restarts from FIRST_REG.
REQ-038 Write r3 <= 32'hCAFEF00D after r3 LOAD but before its bytes complete -> stream still carries old r3 value; start during busy ignored (one done only).
REQ-039 rst_n low mid-pass -> next edge all outputs at reset values, no done; start after reset release gives normal pass.
